// File: rtl/dds_pkg.sv
// Shared DDS definitions: quadrant encodings, FCW update FSM states and the
// accumulator width helper used by the phase generator and the table stage.
package dds_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  typedef enum logic {
    FCW_IDLE    = 1'b0,
    FCW_PENDING = 1'b1
  } fcw_state_t;

  // Accumulator width: quadrant (2) + table address (n) + fraction (n_divide)
  function automatic int acc_width(input int n, input int n_divide);
    return n + 2 + n_divide;
  endfunction

endpackage

// File: rtl/dds_tick_div.sv
// Sample-rate divider: counts enabled clocks and flags every SAMPLE_DIV-th one
// as a phase-step tick. Holds its count while enable is low.
module dds_tick_div #(
  parameter int SAMPLE_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  // Advance the divider on enabled cycles, wrapping to zero on the tick cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator front end: steps the accumulator by the active FCW on
// each divided tick, decodes quadrant and mirrored quarter-wave address, and
// accepts phase-continuous FCW updates over a valid/ready handshake.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int               N              = 8,
  parameter int               N_DIVIDE       = 4,
  parameter int               ACC_W          = acc_width(N, N_DIVIDE),
  parameter int               SAMPLE_DIV     = 1,
  parameter int               UPDATE_AT_WRAP = 0,
  parameter logic [ACC_W-1:0] RESET_FCW      = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] fcw_data,
  input  logic             fcw_valid,
  output logic             fcw_ready,
  input  logic             sync,
  output logic [N-1:0]     angle,
  output logic [1:0]       quadrant,
  output logic             sample_valid,
  output logic             wrap
);

  logic             tick;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fcw_active;
  logic [ACC_W-1:0] fcw_pending;
  fcw_state_t       state;
  logic             sync_pend;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;
  logic [ACC_W-1:0] acc_next;
  quadrant_t        quad_next;
  logic [N-1:0]     raw_next;
  logic [N-1:0]     angle_next;

  dds_tick_div #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  // Next accumulator value, carry, FCW apply condition and table-address decode
  always_comb begin
    sum        = {1'b0, acc} + {1'b0, fcw_active};
    carry      = sum[ACC_W];
    acc_next   = sync_pend ? '0 : sum[ACC_W-1:0];
    apply      = tick && (state == FCW_PENDING) &&
                 ((UPDATE_AT_WRAP == 0) || carry || (fcw_active == '0) || sync_pend);
    quad_next  = quadrant_t'(acc_next[ACC_W-1:ACC_W-2]);
    raw_next   = acc_next[ACC_W-3:N_DIVIDE];
    angle_next = ((quad_next == Q1) || (quad_next == Q3)) ? ~raw_next : raw_next;
  end

  // Step the accumulator on ticks and register the decoded sample outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      angle        <= '0;
      quadrant     <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= tick;
      wrap         <= tick & carry & ~sync_pend;
      if (tick) begin
        acc      <= acc_next;
        quadrant <= quad_next;
        angle    <= angle_next;
      end
    end
  end

  // FCW update FSM: capture into the pending slot, swap it in on the apply tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FCW_IDLE;
      fcw_active  <= RESET_FCW;
      fcw_pending <= '0;
      fcw_ready   <= 1'b1;
    end else begin
      case (state)
        FCW_IDLE: begin
          if (fcw_valid) begin
            fcw_pending <= fcw_data;
            fcw_ready   <= 1'b0;
            state       <= FCW_PENDING;
          end
        end
        FCW_PENDING: begin
          if (apply) begin
            fcw_active <= fcw_pending;
            fcw_ready  <= 1'b1;
            state      <= FCW_IDLE;
          end
        end
        default: begin
          fcw_ready <= 1'b1;
          state     <= FCW_IDLE;
        end
      endcase
    end
  end

  // Remember a sync request until a tick consumes it; a same-cycle tick does not
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_pend <= 1'b0;
    end else begin
      sync_pend <= sync | (sync_pend & ~tick);
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: three configurations share stimulus
// and are compared against an arithmetic reference model of the phase path.
module tb_dds_phase_gen;

  localparam int MOD    = 16384;
  localparam int RFCW_D = 'h30;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        fcw_valid;
  logic [13:0] fcw_data;
  logic        sync;

  logic [7:0] angle_a, angle_w, angle_d;
  logic [1:0] quad_a, quad_w, quad_d;
  logic       sv_a, sv_w, sv_d;
  logic       wrap_a, wrap_w, wrap_d;
  logic       ready_a, ready_w, ready_d;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dds_phase_gen #(.N(8), .N_DIVIDE(4), .SAMPLE_DIV(1), .UPDATE_AT_WRAP(0), .RESET_FCW(14'h0000)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fcw_data(fcw_data), .fcw_valid(fcw_valid),
    .fcw_ready(ready_a), .sync(sync), .angle(angle_a), .quadrant(quad_a), .sample_valid(sv_a), .wrap(wrap_a));

  dds_phase_gen #(.N(8), .N_DIVIDE(4), .SAMPLE_DIV(1), .UPDATE_AT_WRAP(1), .RESET_FCW(14'h0000)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fcw_data(fcw_data), .fcw_valid(fcw_valid),
    .fcw_ready(ready_w), .sync(sync), .angle(angle_w), .quadrant(quad_w), .sample_valid(sv_w), .wrap(wrap_w));

  dds_phase_gen #(.N(8), .N_DIVIDE(4), .SAMPLE_DIV(4), .UPDATE_AT_WRAP(0), .RESET_FCW(14'h0030)) dut_d (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fcw_data(fcw_data), .fcw_valid(fcw_valid),
    .fcw_ready(ready_d), .sync(sync), .angle(angle_d), .quadrant(quad_d), .sample_valid(sv_d), .wrap(wrap_d));

  typedef struct {
    int acc;
    int fcw;
    bit pend_valid;
    int pend;
    bit sync_p;
    int div;
    int angle;
    int quad;
    bit sv;
    bit wrap;
  } model_t;

  model_t m_a, m_w, m_d;

  function automatic model_t reset_model(input int rfcw);
    model_t r;
    r.acc = 0; r.fcw = rfcw; r.pend_valid = 0; r.pend = 0; r.sync_p = 0;
    r.div = 0; r.angle = 0; r.quad = 0; r.sv = 0; r.wrap = 0;
    return r;
  endfunction

  // One clock of the reference behaviour, written from the phase arithmetic
  function automatic model_t model_step(input model_t s, input int sdiv, input bit uaw,
                                        input bit en, input bit fv, input int fd, input bit sy);
    model_t n;
    bit     ready;
    bit     tick;
    int     total;
    bit     carry;
    int     raw;
    n      = s;
    n.sv   = 0;
    n.wrap = 0;
    ready  = !s.pend_valid;
    tick   = 0;
    if (en) begin
      if (s.div == sdiv - 1) begin
        tick  = 1;
        n.div = 0;
      end else begin
        n.div = s.div + 1;
      end
    end
    if (tick) begin
      total = s.acc + s.fcw;
      carry = (total >= MOD);
      if (s.pend_valid && (!uaw || carry || s.fcw == 0 || s.sync_p)) begin
        n.fcw        = s.pend;
        n.pend_valid = 0;
      end
      if (s.sync_p) begin
        n.acc    = 0;
        n.sync_p = 0;
      end else begin
        n.acc  = total % MOD;
        n.wrap = carry;
      end
      n.sv    = 1;
      n.quad  = n.acc / 4096;
      raw     = (n.acc / 16) % 256;
      n.angle = (n.quad % 2 == 1) ? 255 - raw : raw;
    end
    if (sy) n.sync_p = 1;
    if (fv && ready) begin
      n.pend       = fd;
      n.pend_valid = 1;
    end
    return n;
  endfunction

  // Reference model advances on the same edges as the DUTs
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_a <= reset_model(0);
      m_w <= reset_model(0);
      m_d <= reset_model(RFCW_D);
    end else begin
      m_a <= model_step(m_a, 1, 1'b0, enable, fcw_valid, int'(fcw_data), sync);
      m_w <= model_step(m_w, 1, 1'b1, enable, fcw_valid, int'(fcw_data), sync);
      m_d <= model_step(m_d, 4, 1'b0, enable, fcw_valid, int'(fcw_data), sync);
    end
  end

  logic [12:0] obs_a, obs_w, obs_d, exp_a, exp_w, exp_d;
  assign obs_a = {angle_a, quad_a, sv_a, wrap_a, ready_a};
  assign obs_w = {angle_w, quad_w, sv_w, wrap_w, ready_w};
  assign obs_d = {angle_d, quad_d, sv_d, wrap_d, ready_d};
  assign exp_a = {m_a.angle[7:0], m_a.quad[1:0], m_a.sv, m_a.wrap, ~m_a.pend_valid};
  assign exp_w = {m_w.angle[7:0], m_w.quad[1:0], m_w.sv, m_w.wrap, ~m_w.pend_valid};
  assign exp_d = {m_d.angle[7:0], m_d.quad[1:0], m_d.sv, m_d.wrap, ~m_d.pend_valid};

  task automatic apply_stimulus(input bit en, input bit fv, input logic [13:0] fd, input bit sy);
    enable    = en;
    fcw_valid = fv;
    fcw_data  = fd;
    sync      = sy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    apply_stimulus(0, 0, 14'h0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    apply_stimulus(0, 0, 14'h0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if ({obs_a, obs_w, obs_d} !== {13'h001, 13'h001, 13'h001})
      $display("[TB] FAIL reset_state: got %h %h %h expected 001 each", obs_a, obs_w, obs_d);
    else passes++;
    reset_n = 1'b1;
    apply_stimulus(1, 0, 14'h0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== 13'h005) $display("[TB] FAIL reset_idle_a cycle %0d: got %h expected 005", i, obs_a);
      else passes++;
      checks++;
      if (obs_d !== exp_d) $display("[TB] FAIL reset_idle_d cycle %0d: got %h expected %h", i, obs_d, exp_d);
      else passes++;
    end
  endtask

  task automatic test_fcw_step();
    int wraps;
    wraps = 0;
    apply_stimulus(1, 1, 14'h0100, 0);
    @(negedge clk);
    apply_stimulus(1, 0, 14'h0, 0);
    checks++;
    if (ready_a !== 1'b0) $display("[TB] FAIL fcw_capture_ready: got %b expected 0", ready_a);
    else passes++;
    @(negedge clk);
    checks++;
    if ({ready_a, angle_a} !== {1'b1, 8'h00}) $display("[TB] FAIL fcw_apply: got %b/%h expected 1/00", ready_a, angle_a);
    else passes++;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (wrap_a) wraps++;
      checks++;
      if (obs_a !== exp_a) $display("[TB] FAIL fcw_step_a tick %0d: got %h expected %h", k, obs_a, exp_a);
      else passes++;
      checks++;
      if (obs_w !== exp_w) $display("[TB] FAIL fcw_step_w tick %0d: got %h expected %h", k, obs_w, exp_w);
      else passes++;
      if (k == 16) begin
        checks++;
        if ({quad_a, angle_a} !== {2'b01, 8'hFF}) $display("[TB] FAIL quadrant1_mirror: got %h/%h expected 1/ff", quad_a, angle_a);
        else passes++;
      end
      if (k == 64) begin
        checks++;
        if ({quad_a, angle_a, wrap_a} !== {2'b00, 8'h00, 1'b1}) $display("[TB] FAIL wrap_tick: got %h/%h/%b expected 0/00/1", quad_a, angle_a, wrap_a);
        else passes++;
      end
    end
    checks++;
    if (wraps != 1) $display("[TB] FAIL wrap_count: got %0d expected 1", wraps);
    else passes++;
  endtask

  task automatic test_update_at_wrap();
    bit seen;
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) $display("[TB] FAIL uaw_pre tick %0d: got %h expected %h", k, obs_w, exp_w);
      else passes++;
    end
    apply_stimulus(1, 1, 14'h0200, 0);
    @(negedge clk);
    apply_stimulus(1, 0, 14'h0, 0);
    checks++;
    if (ready_w !== 1'b0) $display("[TB] FAIL uaw_capture_ready: got %b expected 0", ready_w);
    else passes++;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) $display("[TB] FAIL uaw_model cycle %0d: got %h expected %h", k, obs_w, exp_w);
      else passes++;
      checks++;
      if (wrap_w) begin
        seen = 1;
        if ({ready_w, quad_w, angle_w} !== {1'b1, 2'b00, 8'h00})
          $display("[TB] FAIL uaw_wrap_apply: got %b/%h/%h expected 1/0/00", ready_w, quad_w, angle_w);
        else passes++;
      end else begin
        if (ready_w !== 1'b0) $display("[TB] FAIL uaw_ready_held cycle %0d: got %b expected 0", k, ready_w);
        else passes++;
      end
    end
    if (!seen) begin
      checks++;
      $display("[TB] FAIL uaw_timeout: got no wrap expected wrap within 80 cycles");
    end
    @(negedge clk);
    checks++;
    if ({quad_w, angle_w} !== {2'b00, 8'h20}) $display("[TB] FAIL uaw_new_step: got %h/%h expected 0/20", quad_w, angle_w);
    else passes++;
  endtask

  task automatic test_sync();
    do_reset();
    apply_stimulus(1, 1, 14'h0234, 0);
    @(negedge clk);
    apply_stimulus(1, 0, 14'h0, 0);
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) $display("[TB] FAIL sync_ramp_a tick %0d: got %h expected %h", k, obs_a, exp_a);
      else passes++;
    end
    checks++;
    if ({quad_a, angle_a} !== {2'b10, 8'h34}) $display("[TB] FAIL sync_start_phase: got %h/%h expected 2/34", quad_a, angle_a);
    else passes++;
    apply_stimulus(0, 1, 14'h0080, 1);
    @(negedge clk);
    apply_stimulus(1, 0, 14'h0, 0);
    checks++;
    if ({ready_a, sv_a, angle_a} !== {1'b0, 1'b0, 8'h34}) $display("[TB] FAIL sync_held: got %b/%b/%h expected 0/0/34", ready_a, sv_a, angle_a);
    else passes++;
    @(negedge clk);
    checks++;
    if (obs_a !== 13'h005) $display("[TB] FAIL sync_zero: got %h expected 005", obs_a);
    else passes++;
    checks++;
    if (obs_w !== exp_w) $display("[TB] FAIL sync_zero_w: got %h expected %h", obs_w, exp_w);
    else passes++;
    @(negedge clk);
    checks++;
    if (obs_a !== 13'h105) $display("[TB] FAIL sync_new_fcw: got %h expected 105", obs_a);
    else passes++;
    checks++;
    if (obs_d !== exp_d) $display("[TB] FAIL sync_d: got %h expected %h", obs_d, exp_d);
    else passes++;
  endtask

  task automatic test_enable_gaps();
    int  en_count;
    int  pulses;
    bit  en;
    bit  want_sv;
    en_count = 0;
    pulses   = 0;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      en = (i < 2) || (i >= 8);
      apply_stimulus(en, 0, 14'h0, 0);
      if (en) en_count++;
      want_sv = en && (en_count % 4 == 0);
      @(negedge clk);
      if (sv_d) pulses++;
      checks++;
      if (sv_d !== want_sv) $display("[TB] FAIL gap_tick cycle %0d: got %b expected %b", i, sv_d, want_sv);
      else passes++;
      checks++;
      if (obs_d !== exp_d) $display("[TB] FAIL gap_model cycle %0d: got %h expected %h", i, obs_d, exp_d);
      else passes++;
    end
    checks++;
    if (pulses != 4) $display("[TB] FAIL gap_pulse_count: got %0d expected 4", pulses);
    else passes++;
    for (int i = 0; i < 60; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 0, 14'h0, 0);
      @(negedge clk);
      checks++;
      if (obs_d !== exp_d) $display("[TB] FAIL gap_random cycle %0d: got %h expected %h", i, obs_d, exp_d);
      else passes++;
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    apply_stimulus(1, 1, 14'h0100, 0);
    @(negedge clk);
    apply_stimulus(1, 0, 14'h0, 0);
    repeat (6) @(negedge clk);
    apply_stimulus(0, 1, 14'h0300, 1);
    @(negedge clk);
    apply_stimulus(0, 0, 14'h0, 0);
    checks++;
    if ({ready_w, angle_w} !== {1'b0, 8'h50}) $display("[TB] FAIL rstp_pending: got %b/%h expected 0/50", ready_w, angle_w);
    else passes++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({obs_a, obs_w, obs_d} !== {13'h001, 13'h001, 13'h001})
      $display("[TB] FAIL rstp_async: got %h %h %h expected 001 each", obs_a, obs_w, obs_d);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1, 0, 14'h0, 0);
    @(negedge clk);
    checks++;
    if (obs_w !== 13'h005) $display("[TB] FAIL rstp_w_first: got %h expected 005", obs_w);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_d !== 13'h065) $display("[TB] FAIL rstp_d_first: got %h expected 065", obs_d);
    else passes++;
    repeat (4) @(negedge clk);
    checks++;
    if ({obs_w, obs_d} !== {13'h005, 13'h0C5}) $display("[TB] FAIL rstp_second: got %h %h expected 005 0c5", obs_w, obs_d);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply_stimulus($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, 14'($urandom), $urandom_range(0, 15) == 0);
      @(negedge clk);
      checks++;
      if ({obs_a, obs_w, obs_d} !== {exp_a, exp_w, exp_d})
        $display("[TB] FAIL random cycle %0d: got %h %h %h expected %h %h %h", i, obs_a, obs_w, obs_d, exp_a, exp_w, exp_d);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_fcw_step();
    test_update_at_wrap();
    test_sync();
    test_enable_gaps();
    test_reset_pending();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
